// File: rtl/proc_arbiter.sv
// proc_arbiter: round-robin owner of the shared processing datapath.
// Ports: per-channel req/mode/proc_val/data/valid in, gnt/done/err out;
// slvx_* drive the datapath, proc_cmplt ends a job, busy flags non-IDLE.
module proc_arbiter #(
    parameter int DW           = 32,
    parameter int NUM_REQ      = 2,
    parameter int FLUSH_CYCLES = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [2*NUM_REQ-1:0]    req_mode,
    input  logic [8*NUM_REQ-1:0]    req_proc_val,
    input  logic [DW*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      err,
    output logic                    busy,
    output logic [1:0]              slvx_mode,
    output logic [7:0]              slvx_proc_val,
    output logic [DW-1:0]           slvx_data,
    output logic                    slvx_data_valid,
    input  logic                    proc_cmplt
);

    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_STREAM,
        S_FLUSH,
        S_RELEASE,
        S_ABORT
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0]      sel_q, sel_d;
    logic [SW-1:0]      rr_q, rr_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         pv_q, pv_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               busy_q, busy_d;
    logic [1:0]         smode_q, smode_d;
    logic [7:0]         spv_q, spv_d;
    logic [DW-1:0]      sdata_q, sdata_d;
    logic               svalid_q, svalid_d;

    logic [NUM_REQ-1:0] sel_oh;
    logic [SW-1:0]      nxt_rr;
    logic               found;
    logic [SW-1:0]      pick;
    int                 idx;

    assign sel_oh = NUM_REQ'(1) << sel_q;
    assign nxt_rr = SW'((int'(sel_q) + 1) % NUM_REQ);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        mode_d   = mode_q;
        pv_d     = pv_q;
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = '0;
        smode_d  = smode_q;
        spv_d    = spv_q;
        sdata_d  = sdata_q;
        svalid_d = 1'b0;
        found    = 1'b0;
        pick     = '0;
        idx      = 0;

        // first requester at or after rr_q, wrapping
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    mode_d  = req_mode[int'(pick)*2 +: 2];
                    pv_d    = req_proc_val[int'(pick)*8 +: 8];
                    state_d = S_CONFIG;
                end
            end
            S_CONFIG: begin
                if (mode_q == 2'b01 || mode_q == 2'b10) begin
                    smode_d = mode_q;
                    spv_d   = pv_q;
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    state_d = S_ABORT;
                end
            end
            S_STREAM: begin
                sdata_d  = req_data[int'(sel_q)*DW +: DW];
                svalid_d = req_valid[sel_q];
                cnt_d    = req_valid[sel_q] ? '0 : cnt_q + 1'b1;
                // completion wins over a same-cycle timeout or withdrawal
                if (proc_cmplt) begin
                    fcnt_d  = '0;
                    state_d = S_FLUSH;
                end else if (!req[sel_q] ||
                             (!req_valid[sel_q] &&
                              int'(cnt_q) + 1 >= TIMEOUT)) begin
                    state_d = S_ABORT;
                end else begin
                    gnt_d = sel_oh;
                end
            end
            S_FLUSH: begin
                if (int'(fcnt_q) == FLUSH_CYCLES - 1) begin
                    state_d = S_RELEASE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                smode_d = 2'b00;
                done_d  = sel_oh;
                rr_d    = nxt_rr;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                smode_d = 2'b00;
                err_d   = sel_oh;
                rr_d    = nxt_rr;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            rr_q     <= '0;
            mode_q   <= '0;
            pv_q     <= '0;
            cnt_q    <= '0;
            fcnt_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            smode_q  <= '0;
            spv_q    <= '0;
            sdata_q  <= '0;
            svalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            mode_q   <= mode_d;
            pv_q     <= pv_d;
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            smode_q  <= smode_d;
            spv_q    <= spv_d;
            sdata_q  <= sdata_d;
            svalid_q <= svalid_d;
        end
    end

    assign gnt             = gnt_q;
    assign done            = done_q;
    assign err             = err_q;
    assign busy            = busy_q;
    assign slvx_mode       = smode_q;
    assign slvx_proc_val   = spv_q;
    assign slvx_data       = sdata_q;
    assign slvx_data_valid = svalid_q;

endmodule

// File: tb/tb_proc_arbiter.sv
// tb_proc_arbiter: randomized jobs against a job-level reference model.
// Requesters and datapath are emulated here; timing derives from job rules.
module tb_proc_arbiter;

    localparam int DW = 32;
    localparam int N  = 3;
    localparam int FC = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [2*N-1:0]    req_mode;
    logic [8*N-1:0]    req_proc_val;
    logic [DW*N-1:0]   req_data;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [N-1:0]      err;
    logic              busy;
    logic [1:0]        slvx_mode;
    logic [7:0]        slvx_proc_val;
    logic [DW-1:0]     slvx_data;
    logic              slvx_data_valid;
    logic              proc_cmplt;

    always #5 clk = ~clk;

    proc_arbiter #(
        .DW(DW), .NUM_REQ(N), .FLUSH_CYCLES(FC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_mode(req_mode),
        .req_proc_val(req_proc_val),
        .req_data(req_data), .req_valid(req_valid),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .slvx_mode(slvx_mode),
        .slvx_proc_val(slvx_proc_val),
        .slvx_data(slvx_data),
        .slvx_data_valid(slvx_data_valid),
        .proc_cmplt(proc_cmplt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int owner = -1;
    int since = 0;
    int rr_m  = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int c);
        logic [N-1:0] r;
        r = '0;
        r[c] = 1'b1;
        return r;
    endfunction

    // round-robin choice from the model pointer over held requests
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr_m + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic noise();
        for (int i = 0; i < N; i++) begin
            if (i != owner) begin
                req_valid[i] = 1'($urandom);
                req_data[i*DW +: DW] = $urandom;
            end
        end
    endtask

    task automatic new_req(input int i);
        int r;
        r = $urandom % 8;
        req[i] = 1'b1;
        if (r == 0)
            req_mode[2*i +: 2] = ($urandom % 2) ? 2'b11 : 2'b00;
        else
            req_mode[2*i +: 2] = ($urandom % 2) ? 2'b01 : 2'b10;
        req_proc_val[8*i +: 8] = 8'($urandom);
    endtask

    task automatic finish_job(input int ch);
        req[ch] = 1'b0;
        req_valid[ch] = 1'b0;
        rr_m = (ch + 1) % N;
        owner = -1;
    endtask

    // one streaming cycle: owner drives v, word must appear next cycle
    task automatic scycle(input int ch, input logic v,
                          input logic [1:0] m, input logic [7:0] pv);
        logic [DW-1:0] d;
        d = $urandom;
        req_valid[ch] = v;
        req_data[ch*DW +: DW] = d;
        req_mode[2*ch +: 2] = 2'($urandom);
        req_proc_val[8*ch +: 8] = 8'($urandom);
        noise();
        for (int i = 0; i < N; i++)
            if (i != ch && !req[i] && ($urandom % 16 == 0)) new_req(i);
        tick();
        since = v ? 0 : since + 1;
        chk("fwd_vld", slvx_data_valid, v);
        if (v) chk("fwd_data", slvx_data, d);
        chk("str_gnt", gnt, oh(ch));
        chk("str_mode", slvx_mode, m);
        chk("str_pv", slvx_proc_val, pv);
        chk("str_pulse", {done, err}, 0);
    endtask

    task automatic do_job(input int ch, input int kind);
        logic [1:0] m;
        logic [7:0] pv;
        logic       v;
        int         nb;
        m  = req_mode[2*ch +: 2];
        pv = req_proc_val[8*ch +: 8];
        owner = ch;
        req_valid[ch] = 1'b0;
        noise();
        tick();
        chk("sel_busy", busy, 1);
        chk("sel_gnt", gnt, 0);
        noise();
        tick();
        if (m == 2'b00 || m == 2'b11) begin
            chk("ill_mode", slvx_mode, 0);
            chk("ill_gnt0", gnt, 0);
            noise();
            tick();
            chk("ill_err", err, oh(ch));
            chk("ill_gnt", gnt, 0);
            chk("ill_vld", slvx_data_valid, 0);
            chk("ill_busy", busy, 0);
            finish_job(ch);
            return;
        end
        chk("cfg_mode", slvx_mode, m);
        chk("cfg_pv", slvx_proc_val, pv);
        chk("cfg_vld", slvx_data_valid, 0);
        chk("cfg_gnt", gnt, 0);
        since = 0;
        scycle(ch, 1'b0, m, pv);
        nb = $urandom_range(1, 10);
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom % 4) scycle(ch, 1'b0, m, pv);
            scycle(ch, 1'b1, m, pv);
        end
        v = 1'($urandom);
        req_valid[ch] = v;
        noise();
        if (kind == 0 || kind == 3) begin
            if (kind == 3) req[ch] = 1'b0;
            proc_cmplt = 1'b1;
            tick();
            proc_cmplt = 1'b0;
            chk("cmp_gnt", gnt, 0);
            chk("cmp_vld", slvx_data_valid, v);
            chk("cmp_mode", slvx_mode, m);
            req_valid[ch] = 1'b0;
            for (int k = 0; k < FC; k++) begin
                noise();
                proc_cmplt = 1'($urandom);
                tick();
                chk("fl_vld", slvx_data_valid, 0);
                chk("fl_mode", slvx_mode, m);
                chk("fl_gnt", gnt, 0);
                chk("fl_busy", busy, 1);
                chk("fl_pulse", {done, err}, 0);
            end
            proc_cmplt = 1'b0;
            noise();
            tick();
            chk("done", done, oh(ch));
            chk("rel_err", err, 0);
            chk("rel_mode", slvx_mode, 0);
            chk("rel_busy", busy, 0);
        end else begin
            if (kind == 1) begin
                req_valid[ch] = 1'b0;
                while (since < TO) begin
                    noise();
                    tick();
                    since++;
                    chk("to_vld", slvx_data_valid, 0);
                    chk("to_gnt", gnt, (since < TO) ? oh(ch) : '0);
                    chk("to_mode", slvx_mode, m);
                    chk("to_pulse", {done, err}, 0);
                end
            end else begin
                req[ch] = 1'b0;
                tick();
                chk("wd_gnt", gnt, 0);
                chk("wd_vld", slvx_data_valid, v);
                chk("wd_mode", slvx_mode, m);
            end
            req_valid[ch] = 1'b0;
            noise();
            tick();
            chk("abt_err", err, oh(ch));
            chk("abt_done", done, 0);
            chk("abt_mode", slvx_mode, 0);
            chk("abt_vld", slvx_data_valid, 0);
            chk("abt_busy", busy, 0);
        end
        finish_job(ch);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (pick() >= 0 && guard < 30) begin
            do_job(pick(), $urandom % 4);
            guard++;
        end
        // stop late arrivals so the next phase starts from IDLE
        while (pick() >= 0) do_job(pick(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mode"}, slvx_mode, 0);
        chk({tag, "_pv"}, slvx_proc_val, 0);
        chk({tag, "_data"}, slvx_data, 0);
        chk({tag, "_vld"}, slvx_data_valid, 0);
    endtask

    initial begin
        logic [N-1:0] mask;
        rst = 1'b1;
        req = '0;
        req_mode = '0;
        req_proc_val = '0;
        req_data = '0;
        req_valid = '0;
        proc_cmplt = 1'b0;
        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b0;
        rr_m = 0;
        noise();
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);

        for (int it = 0; it < 60; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (mask[i]) new_req(i);
            drain();
            repeat ($urandom % 3) begin
                noise();
                proc_cmplt = 1'($urandom);
                tick();
                chk("gap_busy", busy, 0);
                chk("gap_gnt", gnt, 0);
                chk("gap_vld", slvx_data_valid, 0);
            end
            proc_cmplt = 1'b0;
        end

        // reset in the middle of a ch1 job with ch0 and ch2 waiting
        req[1] = 1'b1;
        req_mode[3:2] = 2'b01;
        req_proc_val[15:8] = 8'h80;
        owner = 1;
        noise();
        tick();
        noise();
        tick();
        chk("r_mode", slvx_mode, 2'b01);
        since = 0;
        scycle(1, 1'b0, 2'b01, 8'h80);
        scycle(1, 1'b1, 2'b01, 8'h80);
        req[0] = 1'b1;
        req_mode[1:0] = 2'b10;
        req_proc_val[7:0] = 8'hF0;
        req[2] = 1'b1;
        req_mode[5:4] = 2'b01;
        scycle(1, 1'b1, 2'b01, 8'h80);
        rst = 1'b1;
        noise();
        tick();
        rst = 1'b0;
        chk_reset("mid");
        owner = -1;
        rr_m = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
